// File: rtl/if_id_queue.sv
// IF->ID instruction fetch queue: circular FIFO of {pc, instr} pairs with flush.
// Optional empty-queue bypass enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_instr,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [31:0]              o_addr,
    output logic [31:0]              o_instr,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic not_empty;
    logic bypass;
    logic push;
    logic pop;
    logic [63:0] head;

    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = !not_empty && i_valid && i_ready && !i_flush && !i_reset;
`else
    assign bypass = 1'b0;
`endif

    // Ready looks only at registered occupancy, never at i_ready.
    assign o_ready = (count != FULL) && !i_reset;
    assign push    = i_valid && o_ready && !bypass;
    assign pop     = not_empty && i_ready;

    always_comb begin
        o_valid = not_empty;
        o_addr  = 32'h0;
        o_instr = NOP_INSTR;
        if (not_empty) begin
            o_addr  = head[63:32];
            o_instr = head[31:0];
        end else if (bypass) begin
            o_valid = 1'b1;
            o_addr  = i_addr;
            o_instr = i_instr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Storage contents are left stale; count==0 hides them.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {i_addr, i_instr};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_count = count;

endmodule
